// File: rtl/cpu_pkg.sv
// Shared constants and types for the cpu_pipe core: opcodes, CSR bases,
// NOP encoding, ALU operation enum and the decoded-instruction bundle.
package cpu_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [11:0] CSR_GPIO_IN_BASE  = 12'hF00;
  localparam logic [11:0] CSR_GPIO_OUT_BASE = 12'hF20;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    a_sel_e      a_sel;
    logic        b_imm;
    logic        regwrite;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        csr;
    logic [2:0]  funct3;
  } dec_t;
endpackage

// File: rtl/alu.sv
// RV32I integer ALU, purely combinational.
module alu
  import cpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_y
);
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_SLL:  o_y = i_a << i_b[4:0];
      ALU_SLT:  o_y = {31'b0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_y = {31'b0, i_a < i_b};
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SRL:  o_y = i_a >> i_b[4:0];
      ALU_SRA:  o_y = $unsigned($signed(i_a) >>> i_b[4:0]);
      ALU_OR:   o_y = i_a | i_b;
      ALU_AND:  o_y = i_a & i_b;
      default:  o_y = '0;
    endcase
  end
endmodule

// File: rtl/branch_unit.sv
// Branch comparator and word-address target for branches, JAL and JALR.
module branch_unit
  import cpu_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          i_branch,
  input  logic          i_jal,
  input  logic          i_jalr,
  input  logic [2:0]    i_funct3,
  input  logic [31:0]   i_rs1,
  input  logic [31:0]   i_rs2,
  input  logic [31:0]   i_imm,
  input  logic [AW-1:0] i_pc,
  output logic          o_taken,
  output logic [AW-1:0] o_target
);
  logic        w_cond;
  logic [31:0] w_sum;

  always_comb begin
    w_cond = 1'b0;
    case (i_funct3)
      3'b000:  w_cond = (i_rs1 == i_rs2);
      3'b001:  w_cond = (i_rs1 != i_rs2);
      3'b100:  w_cond = ($signed(i_rs1) <  $signed(i_rs2));
      3'b101:  w_cond = ($signed(i_rs1) >= $signed(i_rs2));
      3'b110:  w_cond = (i_rs1 <  i_rs2);
      3'b111:  w_cond = (i_rs1 >= i_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  // clearing bit 0 for JALR is implied: the word address drops bits [1:0]
  assign w_sum    = (i_jalr ? i_rs1 : 32'({i_pc, 2'b00})) + i_imm;
  assign o_target = AW'(w_sum >> 2);
  assign o_taken  = i_jal || i_jalr || (i_branch && w_cond);
endmodule

// File: rtl/inst_decoder.sv
// RV32I subset decoder; anything unsupported decodes to a no-write NOP.
module inst_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] i_insn,
  output dec_t        o_dec
);
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_f7b5;
  logic [31:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;

  assign w_op    = i_insn[6:0];
  assign w_f3    = i_insn[14:12];
  assign w_f7b5  = i_insn[30];
  assign w_imm_i = {{20{i_insn[31]}}, i_insn[31:20]};
  assign w_imm_b = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
  assign w_imm_u = {i_insn[31:12], 12'b0};
  assign w_imm_j = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};

  function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    o_dec        = '0;
    o_dec.rs1    = i_insn[19:15];
    o_dec.rs2    = i_insn[24:20];
    o_dec.rd     = i_insn[11:7];
    o_dec.funct3 = w_f3;
    o_dec.alu_op = ALU_ADD;
    o_dec.a_sel  = A_RS1;
    case (w_op)
      OP_LUI: begin
        o_dec.imm = w_imm_u; o_dec.a_sel = A_ZERO; o_dec.b_imm = 1'b1; o_dec.regwrite = 1'b1;
      end
      OP_AUIPC: begin
        o_dec.imm = w_imm_u; o_dec.a_sel = A_PC; o_dec.b_imm = 1'b1; o_dec.regwrite = 1'b1;
      end
      OP_IMM: begin
        // only shift-right immediates carry the arithmetic flag in bit 30
        o_dec.imm = w_imm_i; o_dec.b_imm = 1'b1; o_dec.regwrite = 1'b1;
        o_dec.alu_op = f3_op(w_f3, (w_f3 == 3'b101) && w_f7b5);
      end
      OP_REG: begin
        o_dec.alu_op = f3_op(w_f3, w_f7b5); o_dec.regwrite = 1'b1;
      end
      OP_JAL: begin
        o_dec.imm = w_imm_j; o_dec.jal = 1'b1; o_dec.regwrite = 1'b1;
      end
      OP_JALR: if (w_f3 == 3'b000) begin
        o_dec.imm = w_imm_i; o_dec.jalr = 1'b1; o_dec.regwrite = 1'b1;
      end
      OP_BRANCH: if (w_f3 != 3'b010 && w_f3 != 3'b011) begin
        o_dec.imm = w_imm_b; o_dec.branch = 1'b1;
      end
      OP_SYSTEM: if (w_f3 == 3'b001) begin
        o_dec.imm = w_imm_i; o_dec.csr = 1'b1; o_dec.regwrite = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, write-first, x0 fixed at 0.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);
  logic [31:0] r_regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : (i_we && i_wa == i_ra1) ? i_wd : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : (i_we && i_wa == i_ra2) ? i_wd : r_regs[i_ra2];
endmodule

// File: rtl/cpu_pipe.sv
// Three-stage (F / EX / WB) RV32I subset core with GPIO channels mapped as CSRs.
module cpu_pipe
  import cpu_pkg::*;
#(
  parameter int IMEM_AW    = 12,
  parameter int N_GPIO_IN  = 1,
  parameter int N_GPIO_OUT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [IMEM_AW-1:0]          imem_addr,
  input  logic [31:0]                 imem_rdata,
  input  logic [N_GPIO_IN-1:0][31:0]  gpio_in,
  output logic [N_GPIO_OUT-1:0][31:0] gpio_out
);
  logic [IMEM_AW-1:0] r_pc_f, r_pc_ex;
  logic [31:0]        r_ir_ex;
  logic               r_regwrite_wb, r_csr_wb;
  logic [4:0]         r_rd_wb;
  logic [31:0]        r_wdata_wb, r_csr_wval_wb;
  logic [11:0]        r_csr_addr_wb;

  dec_t               w_dec;
  logic [31:0]        w_rf1, w_rf2, w_op1, w_op2, w_a, w_b, w_alu;
  logic [31:0]        w_pc_byte, w_link, w_wb_data, w_csr_rdata;
  logic               w_fwd_ok, w_taken;
  logic [IMEM_AW-1:0] w_target;

  inst_decoder u_dec (.i_insn(r_ir_ex), .o_dec(w_dec));

  regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ra1 (w_dec.rs1),
    .i_ra2 (w_dec.rs2),
    .o_rd1 (w_rf1),
    .o_rd2 (w_rf2),
    .i_we  (r_regwrite_wb),
    .i_wa  (r_rd_wb),
    .i_wd  (w_wb_data)
  );

  assign w_fwd_ok = r_regwrite_wb && (r_rd_wb != 5'd0);
  assign w_op1    = (w_fwd_ok && r_rd_wb == w_dec.rs1) ? w_wb_data : w_rf1;
  assign w_op2    = (w_fwd_ok && r_rd_wb == w_dec.rs2) ? w_wb_data : w_rf2;

  assign w_pc_byte = 32'({r_pc_ex, 2'b00});
  assign w_link    = w_pc_byte + 32'd4;

  always_comb begin
    w_a = w_op1;
    case (w_dec.a_sel)
      A_PC:    w_a = w_pc_byte;
      A_ZERO:  w_a = '0;
      default: w_a = w_op1;
    endcase
  end
  assign w_b = w_dec.b_imm ? w_dec.imm : w_op2;

  alu u_alu (.i_a(w_a), .i_b(w_b), .i_op(w_dec.alu_op), .o_y(w_alu));

  branch_unit #(.AW(IMEM_AW)) u_br (
    .i_branch (w_dec.branch),
    .i_jal    (w_dec.jal),
    .i_jalr   (w_dec.jalr),
    .i_funct3 (w_dec.funct3),
    .i_rs1    (w_op1),
    .i_rs2    (w_op2),
    .i_imm    (w_dec.imm),
    .i_pc     (r_pc_ex),
    .o_taken  (w_taken),
    .o_target (w_target)
  );

  // a taken redirect squashes the instruction fetched this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_f  <= '0;
      r_pc_ex <= '0;
      r_ir_ex <= NOP_INSN;
    end else if (w_taken) begin
      r_pc_f  <= w_target;
      r_ir_ex <= NOP_INSN;
    end else begin
      r_pc_f  <= r_pc_f + IMEM_AW'(1);
      r_pc_ex <= r_pc_f;
      r_ir_ex <= imem_rdata;
    end
  end
  assign imem_addr = r_pc_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite_wb <= 1'b0;
      r_csr_wb      <= 1'b0;
      r_rd_wb       <= '0;
      r_wdata_wb    <= '0;
      r_csr_addr_wb <= '0;
      r_csr_wval_wb <= '0;
    end else begin
      r_regwrite_wb <= w_dec.regwrite;
      r_csr_wb      <= w_dec.csr;
      r_rd_wb       <= w_dec.rd;
      r_wdata_wb    <= (w_dec.jal || w_dec.jalr) ? w_link : w_alu;
      r_csr_addr_wb <= w_dec.imm[11:0];
      r_csr_wval_wb <= w_op1;
    end
  end

  // CSR reads resolve in WB so gpio_in is sampled in that cycle; unmapped reads give 0
  always_comb begin
    w_csr_rdata = '0;
    for (int k = 0; k < N_GPIO_IN; k++)
      if (r_csr_addr_wb == CSR_GPIO_IN_BASE + 12'(k)) w_csr_rdata = gpio_in[k];
    for (int k = 0; k < N_GPIO_OUT; k++)
      if (r_csr_addr_wb == CSR_GPIO_OUT_BASE + 12'(k)) w_csr_rdata = gpio_out[k];
  end
  assign w_wb_data = r_csr_wb ? w_csr_rdata : r_wdata_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= '0;
    end else if (r_csr_wb) begin
      for (int k = 0; k < N_GPIO_OUT; k++)
        if (r_csr_addr_wb == CSR_GPIO_OUT_BASE + 12'(k)) gpio_out[k] <= r_csr_wval_wb;
    end
  end
endmodule

// File: tb/tb_cpu_pipe.sv
// Directed bench for cpu_pipe: forwarding, branch bubble, GPIO CSRs, PC wrap, reset during JALR.
module tb_cpu_pipe;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;

  logic [31:0]       mem [4096];
  logic [11:0]       imem_addr;
  logic [31:0]       imem_rdata;
  logic [0:0][31:0]  gpio_in;
  logic [0:0][31:0]  gpio_out;

  logic [31:0]       mem2 [16];
  logic [3:0]        imem_addr2;
  logic [31:0]       imem_rdata2;
  logic [0:0][31:0]  gpio_in2;
  logic [0:0][31:0]  gpio_out2;

  assign imem_rdata  = mem[imem_addr];
  assign imem_rdata2 = mem2[imem_addr2];

  cpu_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out)
  );

  cpu_pipe #(.IMEM_AW(4)) dut2 (
    .clk        (clk),
    .rst_n      (rst2_n),
    .imem_addr  (imem_addr2),
    .imem_rdata (imem_rdata2),
    .gpio_in    (gpio_in2),
    .gpio_out   (gpio_out2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = NOP;
  endtask

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    return {20'(imm20), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] j;
    j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'h6F};
  endfunction

  initial begin
    gpio_in  = '0;
    gpio_in2 = '0;
    for (int i = 0; i < 16; i++) mem2[i] = NOP;
    mem2[0] = enc_j(-4, 1);

    // forwarding: ADDI x1,x0,5 ; ADDI x2,x1,3
    clear_mem();
    mem[0] = enc_i(5, 0, 0, 1, 7'h13);
    mem[1] = enc_i(3, 1, 0, 2, 7'h13);
    restart();
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_gpio", gpio_out[0], 32'd0);
    step(1);
    check("fwd_pc1", 32'(imem_addr), 32'd1);
    step(3);
    check("fwd_x1", dut.u_rf.r_regs[1], 32'd5);
    check("fwd_x2", dut.u_rf.r_regs[2], 32'd8);
    check("fwd_nostall_pc", 32'(imem_addr), 32'd4);

    // reset clears registers written by the previous program
    restart();
    check("rst_x1", dut.u_rf.r_regs[1], 32'd0);
    check("rst_x2", dut.u_rf.r_regs[2], 32'd0);
    check("rst_pc2", 32'(imem_addr), 32'd0);

    // BEQ x0,x0,+8 at address 4
    clear_mem();
    mem[4] = enc_b(8, 0, 0, 0);
    mem[5] = enc_i(1, 0, 0, 6, 7'h13);
    mem[6] = enc_i(2, 0, 0, 7, 7'h13);
    restart();
    step(5);
    check("beq_pc_before", 32'(imem_addr), 32'd5);
    step(1);
    check("beq_target", 32'(imem_addr), 32'd6);
    step(1);
    check("beq_next", 32'(imem_addr), 32'd7);
    step(4);
    check("beq_squashed_x6", dut.u_rf.r_regs[6], 32'd0);
    check("beq_target_x7", dut.u_rf.r_regs[7], 32'd2);

    // GPIO CSRs
    clear_mem();
    gpio_in[0] = 32'h0001_2345;
    mem[0] = enc_u(32'hAC, 4, 7'h37);
    mem[1] = enc_i(-802, 4, 0, 4, 7'h13);
    mem[2] = enc_i(32'hF20, 4, 1, 5, 7'h73);
    mem[3] = enc_i(32'hF00, 0, 1, 3, 7'h73);
    mem[4] = enc_i(32'h123, 4, 1, 4, 7'h73);
    mem[5] = enc_i(32'hF20, 0, 1, 6, 7'h73);
    restart();
    step(4);
    check("csr_gpio_in_wb", gpio_out[0], 32'd0);
    step(1);
    check("csr_gpio_written", gpio_out[0], 32'h000A_BCDE);
    step(2);
    check("csr_gpio_held", gpio_out[0], 32'h000A_BCDE);
    step(1);
    check("csr_x5_old", dut.u_rf.r_regs[5], 32'd0);
    check("csr_x3_in", dut.u_rf.r_regs[3], 32'h0001_2345);
    check("csr_unmapped_x4", dut.u_rf.r_regs[4], 32'd0);
    check("csr_x6_old", dut.u_rf.r_regs[6], 32'h000A_BCDE);
    check("csr_gpio_cleared", gpio_out[0], 32'd0);

    // JALR x2,0(x1) with x1=40, run to completion
    clear_mem();
    mem[0] = enc_i(40, 0, 0, 1, 7'h13);
    mem[1] = enc_i(32'hF20, 1, 1, 0, 7'h73);
    mem[3] = enc_i(0, 1, 0, 2, 7'h67);
    restart();
    step(5);
    check("jalr_target", 32'(imem_addr), 32'd10);
    step(1);
    check("jalr_link", dut.u_rf.r_regs[2], 32'd16);

    // same program, reset asserted while JALR is in EX
    restart();
    step(4);
    check("jalr_pre_pc", 32'(imem_addr), 32'd4);
    check("jalr_pre_gpio", gpio_out[0], 32'd40);
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", 32'(imem_addr), 32'd0);
    check("async_rst_gpio", gpio_out[0], 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_pc", 32'(imem_addr), 32'd0);
    step(1);
    check("post_rst_no_link", dut.u_rf.r_regs[2], 32'd0);
    check("post_rst_pc1", 32'(imem_addr), 32'd1);

    // JAL x1,-4 at PC 0 with a 4-bit PC
    @(negedge clk);
    rst2_n = 1'b1;
    step(1);
    check("wrap_pc1", 32'(imem_addr2), 32'd1);
    step(1);
    check("wrap_pc15", 32'(imem_addr2), 32'd15);
    step(1);
    check("wrap_link", dut2.u_rf.r_regs[1], 32'd4);
    check("wrap_pc0", 32'(imem_addr2), 32'd0);
    check("wrap_gpio", gpio_out2[0], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_pipe.md
CPU_PIPE -- requirements
Module: cpu_pipe

Interface
REQ-001 SHALL have parameter IMEM_AW, default 12, meaning instruction-memory word-address width (depth 2**IMEM_AW).
REQ-002 SHALL have parameter N_GPIO_IN, default 1, meaning number of 32-bit input channels (range 1..16).
REQ-003 SHALL have parameter N_GPIO_OUT, default 1, meaning number of 32-bit output channels (range 1..16).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port imem_addr, output, IMEM_AW bits: word address of the instruction being fetched, equal to PC_F.
REQ-007 SHALL have port imem_rdata, input, 32 bits: instruction at imem_addr, combinational (same-cycle) read.
REQ-008 SHALL have port gpio_in, input, N_GPIO_IN x 32 bits: input channel values, sampled at WB.
REQ-009 SHALL have port gpio_out, output, N_GPIO_OUT x 32 bits: registered output channel values.

Function
REQ-010 SHALL implement three stages: F (PC_F, IR_EX register), EX (decode, register read, ALU, branch resolve), WB (register-file or GPIO write).
REQ-011 SHALL, each non-redirect cycle, set PC_F <= PC_F+1 (wrapping modulo 2**IMEM_AW) and IR_EX <= imem_rdata.
REQ-012 SHALL support RV32I R/I ALU ops, shifts, LUI, AUIPC, BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR and CSRRW; any other opcode SHALL execute as NOP.
REQ-013 SHALL resolve branches/jumps in EX; when taken: PC_F <= target word address, IR_EX <= NOP (0x00000013), giving exactly one bubble.
REQ-014 SHALL compute byte-offset targets as (PC_EX*4 + imm) >> 2; JALR SHALL clear bit 0 before the shift; the upper address bits SHALL be truncated (wrap).
REQ-015 SHALL write PC_EX*4+4 to rd for JAL/JALR.
REQ-016 SHALL forward the WB write data to either EX operand when regwrite_WB=1, rd_WB != 0 and rd_WB equals rs1_EX/rs2_EX; otherwise the register-file read is used.
REQ-017 SHALL hold x0 at zero; writes to x0 SHALL be discarded.
REQ-018 SHALL decode CSR address 0xF00+k (k<N_GPIO_IN) as read-only input channel k and 0xF20+k (k<N_GPIO_OUT) as output channel k.
REQ-019 CSRRW to 0xF20+k SHALL, at the WB edge, write rd <= old gpio_out[k] and gpio_out[k] <= forwarded rs1.
REQ-020 CSRRW from 0xF00+k SHALL write rd <= gpio_in[k] as sampled in the WB cycle; any write to it SHALL be ignored.
REQ-021 CSRRW to an unmapped CSR SHALL write rd <= 0 and change no gpio_out.
REQ-022 gpio_out SHALL change only on CSRRW writes; the register file SHALL use write-first semantics, including for same-cycle WB write and EX read.

Reset
REQ-023 rst_n low SHALL asynchronously force PC_F=0, IR_EX=NOP, all WB-stage controls to 0 (no write), all gpio_out=0, and all x1..x31=0.
REQ-024 Reset asserted mid-branch or mid-write SHALL cancel the pending write; the first fetch after deassertion SHALL be from address 0.

Structure
REQ-025 SHALL place opcode constants, the CSR base addresses (0xF00, 0xF20), the NOP encoding and the ALU-op enum in shared package cpu_pkg.
REQ-026 SHALL reuse the existing inst_decoder, alu and regfile blocks, and add one new sub-module, branch_unit (comparator plus target computation).

Verification
REQ-027 Bench SHALL run: ADDI x1,x0,5; ADDI x2,x1,3 back-to-back -> x2=8 via forwarding, with no stall.
REQ-028 Bench SHALL run: BEQ x0,x0,+8 at addr 4 -> the next fetched address is 6, the instruction at addr 5 never writes, one bubble.
REQ-029 Bench SHALL run: gpio_in[0]=0x12345; CSRRW x3,0xF00,x0 -> x3=0x12345, gpio_out unchanged.
REQ-030 Bench SHALL run: x4=0xABCDE; CSRRW x5,0xF20,x4 -> gpio_out[0]=0xABCDE one cycle after WB, x5=old value 0.
REQ-031 Bench SHALL run: JAL x1,-4 at PC 0 with IMEM_AW=4 -> PC wraps to 15, x1=4.
REQ-032 Bench SHALL assert rst_n for one cycle during a taken JALR -> PC_F=0 immediately, no rd write, gpio_out=0.
